rx_timer_ctrl: RTL and testbench

- Receive-side control unit that sequences the bit-period/data-size timer for the serial receiver.
- Detects and qualifies the start bit, then enables the timer for one frame.
- Checks the stop bit and hands completed frames to the receive buffer with ready/overrun/framing status.
- Owns the timer's runtime configuration (bit period, data size); that configuration is writable only while idle.

---
 rtl/rx_pkg.sv | 19 +
 rtl/start_bit_det.sv | 31 +++
 rtl/rx_timer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_rx_timer_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and constants for the serial receive control path.
package rx_pkg;

  localparam int BIT_PERIOD_W = 14;
  localparam int DATA_SIZE_W  = 4;

  localparam logic [BIT_PERIOD_W-1:0] PKG_DEF_BIT_PERIOD = 14'd10;
  localparam logic [DATA_SIZE_W-1:0]  PKG_DEF_DATA_SIZE  = 4'd8;
  localparam logic [BIT_PERIOD_W-1:0] PKG_MIN_BIT_PERIOD = 14'd4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    RECEIVE   = 3'd2,
    STOP_CHK  = 3'd3,
    LOAD      = 3'd4
  } rx_state_t;

endpackage

// File: rtl/start_bit_det.sv
// Two-flop synchronizer for the raw receive line plus a history flop that
// flags a high-to-low transition of the synchronized line.
module start_bit_det (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic sync,
  output logic start_edge
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  // Reset to 1 so an idle-high line never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign sync       = sync2_q;
  assign start_edge = hist_q & ~sync2_q;

endmodule

// File: rtl/rx_timer_ctrl.sv
// Receive-side sequencer: qualifies the start bit, runs the bit timer for one
// frame, checks the stop bit and posts the frame to the rx buffer with status.
module rx_timer_ctrl
  import rx_pkg::*;
#(
  parameter logic [BIT_PERIOD_W-1:0] DEF_BIT_PERIOD = PKG_DEF_BIT_PERIOD,
  parameter logic [DATA_SIZE_W-1:0]  DEF_DATA_SIZE  = PKG_DEF_DATA_SIZE,
  parameter logic [BIT_PERIOD_W-1:0] MIN_BIT_PERIOD = PKG_MIN_BIT_PERIOD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    serial_in,
  input  logic                    cfg_valid,
  input  logic [BIT_PERIOD_W-1:0] cfg_bit_period,
  input  logic [DATA_SIZE_W-1:0]  cfg_data_size,
  output logic                    cfg_ready,
  output logic                    cfg_err,
  input  logic                    shift_strobe,
  input  logic                    packet_done,
  input  logic                    stop_bit,
  input  logic                    data_read,
  output logic                    enable_timer,
  output logic [BIT_PERIOD_W-1:0] bit_period,
  output logic [DATA_SIZE_W-1:0]  data_size,
  output logic                    sbc_clear,
  output logic                    load_buffer,
  output logic                    data_ready,
  output logic                    framing_error,
  output logic                    overrun_error,
  output logic [2:0]              dbg_state
);

  rx_state_t               state_q;
  logic [BIT_PERIOD_W-1:0] half_cnt_q;
  logic [BIT_PERIOD_W-1:0] bit_period_q;
  logic [DATA_SIZE_W-1:0]  data_size_q;
  logic                    stop_q;
  logic                    enable_timer_q, cfg_ready_q, cfg_err_q;
  logic                    sbc_clear_q, load_buffer_q;
  logic                    data_ready_q, framing_error_q, overrun_error_q;

  logic sync;
  logic start_edge;
  logic cfg_ok;
  logic half_done;
  logic unused_shift_strobe;

  // Bit-centre strobes are consumed by the timer/shift register, not here.
  assign unused_shift_strobe = shift_strobe;

  start_bit_det u_start_bit_det (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .sync      (sync),
    .start_edge(start_edge)
  );

  assign cfg_ok    = (cfg_bit_period >= MIN_BIT_PERIOD) &&
                     (cfg_data_size != '0) && (cfg_data_size <= 4'd8);
  assign half_done = (half_cnt_q == (bit_period_q >> 1));

  // Valid/ready on the config port: a write is taken on any cycle where
  // cfg_valid && cfg_ready, unless a start edge claims that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      half_cnt_q      <= '0;
      bit_period_q    <= DEF_BIT_PERIOD;
      data_size_q     <= DEF_DATA_SIZE;
      stop_q          <= 1'b0;
      enable_timer_q  <= 1'b0;
      cfg_ready_q     <= 1'b1;
      cfg_err_q       <= 1'b0;
      sbc_clear_q     <= 1'b0;
      load_buffer_q   <= 1'b0;
      data_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      cfg_err_q     <= 1'b0;
      sbc_clear_q   <= 1'b0;
      load_buffer_q <= 1'b0;
      if (data_read) begin
        data_ready_q    <= 1'b0;
        overrun_error_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q         <= START_CHK;
            cfg_ready_q     <= 1'b0;
            sbc_clear_q     <= 1'b1;
            framing_error_q <= 1'b0;
            half_cnt_q      <= '0;
          end else if (cfg_valid) begin
            if (cfg_ok) begin
              bit_period_q <= cfg_bit_period;
              data_size_q  <= cfg_data_size;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        START_CHK: begin
          // Re-sample the line half a bit in; still low means a real start bit.
          if (half_done) begin
            if (!sync) begin
              state_q        <= RECEIVE;
              enable_timer_q <= 1'b1;
            end else begin
              state_q     <= IDLE;
              cfg_ready_q <= 1'b1;
            end
          end else begin
            half_cnt_q <= half_cnt_q + 1'b1;
          end
        end
        RECEIVE: begin
          if (packet_done) begin
            state_q        <= STOP_CHK;
            enable_timer_q <= 1'b0;
            stop_q         <= stop_bit;
          end
        end
        STOP_CHK: begin
          if (stop_q) begin
            state_q       <= LOAD;
            load_buffer_q <= 1'b1;
          end else begin
            state_q         <= IDLE;
            cfg_ready_q     <= 1'b1;
            framing_error_q <= 1'b1;
          end
        end
        LOAD: begin
          // A read landing on the load cycle consumed the old byte: no overrun.
          state_q         <= IDLE;
          cfg_ready_q     <= 1'b1;
          data_ready_q    <= 1'b1;
          overrun_error_q <= data_read ? 1'b0 : (overrun_error_q | data_ready_q);
        end
        default: begin
          state_q     <= IDLE;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign cfg_err       = cfg_err_q;
  assign enable_timer  = enable_timer_q;
  assign bit_period    = bit_period_q;
  assign data_size     = data_size_q;
  assign sbc_clear     = sbc_clear_q;
  assign load_buffer   = load_buffer_q;
  assign data_ready    = data_ready_q;
  assign framing_error = framing_error_q;
  assign overrun_error = overrun_error_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rx_timer_ctrl.sv
// Self-checking bench for rx_timer_ctrl: config table, hand-written frame
// sequences and a randomized transaction mix against a flag-level model.
module tb_rx_timer_ctrl;
  import rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        serial_in;
  logic        cfg_valid;
  logic [13:0] cfg_bit_period;
  logic [3:0]  cfg_data_size;
  logic        cfg_ready, cfg_err;
  logic        shift_strobe, packet_done, stop_bit, data_read;
  logic        enable_timer;
  logic [13:0] bit_period;
  logic [3:0]  data_size;
  logic        sbc_clear, load_buffer, data_ready, framing_error, overrun_error;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: configuration and status flags.
  int m_bp, m_ds;
  bit m_ready, m_ovr, m_frm;

  typedef struct {
    int period;
    int size;
    bit exp_err;
    int exp_bp;
    int exp_ds;
  } cfg_vec_t;
  cfg_vec_t cfg_tab[8];

  rx_timer_ctrl dut (
    .clk(clk), .rst(rst), .serial_in(serial_in),
    .cfg_valid(cfg_valid), .cfg_bit_period(cfg_bit_period), .cfg_data_size(cfg_data_size),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .shift_strobe(shift_strobe), .packet_done(packet_done), .stop_bit(stop_bit),
    .data_read(data_read), .enable_timer(enable_timer),
    .bit_period(bit_period), .data_size(data_size),
    .sbc_clear(sbc_clear), .load_buffer(load_buffer), .data_ready(data_ready),
    .framing_error(framing_error), .overrun_error(overrun_error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_data_ready"}, 32'(data_ready), 32'(m_ready));
    check({tag, "_overrun"}, 32'(overrun_error), 32'(m_ovr));
    check({tag, "_framing"}, 32'(framing_error), 32'(m_frm));
  endtask

  task automatic do_config(input int period, input int size);
    bit ok;
    ok = (period >= 4) && (size >= 1) && (size <= 8);
    cfg_valid = 1'b1;
    cfg_bit_period = 14'(period);
    cfg_data_size = 4'(size);
    tick();
    cfg_valid = 1'b0;
    check("rnd_cfg_err", 32'(cfg_err), 32'(!ok));
    if (ok) begin
      m_bp = period;
      m_ds = size;
    end
    check("rnd_cfg_bp", 32'(bit_period), 32'(m_bp));
    check("rnd_cfg_ds", 32'(data_size), 32'(m_ds));
  endtask

  // Line low long enough to pass the half-bit check, then emulate the timer.
  task automatic do_frame(input bit stop, input bit rd_at_load, input int body);
    int lat;
    lat = 0;
    serial_in = 1'b0;
    while (enable_timer !== 1'b1 && lat < 20000) begin
      tick();
      lat++;
    end
    check("start_latency", 32'(lat), 32'(4 + (m_bp / 2)));
    m_frm = 1'b0;
    check("frm_cleared_at_start", 32'(framing_error), 32'd0);
    check("cfg_ready_busy", 32'(cfg_ready), 32'd0);
    repeat (body) tick();
    check("enable_in_receive", 32'(enable_timer), 32'd1);
    serial_in = 1'b1;
    stop_bit = stop;
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    check("enable_after_done", 32'(enable_timer), 32'd0);
    check("no_load_in_stop_chk", 32'(load_buffer), 32'd0);
    tick();
    if (stop) begin
      check("load_pulse", 32'(load_buffer), 32'd1);
      data_read = rd_at_load;
      tick();
      data_read = 1'b0;
      check("load_single", 32'(load_buffer), 32'd0);
      m_ovr = rd_at_load ? 1'b0 : (m_ovr | m_ready);
      m_ready = 1'b1;
    end else begin
      check("no_load_bad_stop", 32'(load_buffer), 32'd0);
      m_frm = 1'b1;
    end
    check("cfg_ready_after_frame", 32'(cfg_ready), 32'd1);
    check_flags("frame");
  endtask

  task automatic do_glitch();
    int en_seen;
    en_seen = 0;
    serial_in = 1'b0;
    tick();
    tick();
    serial_in = 1'b1;
    tick();
    check("start_chk_entry", 32'(dbg_state), 32'(START_CHK));
    check("sbc_clear_pulse", 32'(sbc_clear), 32'd1);
    m_frm = 1'b0;
    repeat (m_bp / 2) begin
      tick();
      if (enable_timer) en_seen++;
    end
    check("glitch_still_start_chk", 32'(dbg_state), 32'(START_CHK));
    tick();
    if (enable_timer) en_seen++;
    check("glitch_back_idle", 32'(dbg_state), 32'(IDLE));
    check("glitch_no_enable", 32'(en_seen), 32'd0);
    check("glitch_cfg_ready", 32'(cfg_ready), 32'd1);
    check_flags("glitch");
  endtask

  task automatic do_read();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    check_flags("read");
  endtask

  initial begin
    cfg_tab[0] = '{20, 7, 1'b0, 20, 7};
    cfg_tab[1] = '{3, 7, 1'b1, 20, 7};
    cfg_tab[2] = '{4, 1, 1'b0, 4, 1};
    cfg_tab[3] = '{4, 0, 1'b1, 4, 1};
    cfg_tab[4] = '{100, 9, 1'b1, 4, 1};
    cfg_tab[5] = '{16383, 8, 1'b0, 16383, 8};
    cfg_tab[6] = '{0, 5, 1'b1, 16383, 8};
    cfg_tab[7] = '{10, 8, 1'b0, 10, 8};

    rst = 1'b1;
    serial_in = 1'b1;
    cfg_valid = 1'b0;
    cfg_bit_period = '0;
    cfg_data_size = '0;
    shift_strobe = 1'b0;
    packet_done = 1'b0;
    stop_bit = 1'b0;
    data_read = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    m_bp = 10; m_ds = 8; m_ready = 0; m_ovr = 0; m_frm = 0;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_enable", 32'(enable_timer), 32'd0);
    check("rst_bit_period", 32'(bit_period), 32'd10);
    check("rst_data_size", 32'(data_size), 32'd8);
    check("rst_load", 32'(load_buffer), 32'd0);
    check_flags("rst");

    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit_period = 14'(cfg_tab[i].period);
      cfg_data_size = 4'(cfg_tab[i].size);
      tick();
      cfg_valid = 1'b0;
      check("tab_cfg_err", 32'(cfg_err), 32'(cfg_tab[i].exp_err));
      check("tab_bit_period", 32'(bit_period), 32'(cfg_tab[i].exp_bp));
      check("tab_data_size", 32'(data_size), 32'(cfg_tab[i].exp_ds));
      tick();
      check("tab_cfg_err_one_cycle", 32'(cfg_err), 32'd0);
    end
    m_bp = 10; m_ds = 8;

    do_glitch();
    do_frame(1'b1, 1'b0, 30);
    do_frame(1'b0, 1'b0, 12);
    do_frame(1'b1, 1'b0, 5);
    do_read();
    do_frame(1'b1, 1'b0, 8);
    do_frame(1'b1, 1'b1, 8);

    // Reset in the middle of a frame, with non-default config loaded.
    do_config(20, 7);
    serial_in = 1'b0;
    for (int i = 0; i < 100 && enable_timer !== 1'b1; i++) tick();
    check("pre_rst_enable", 32'(enable_timer), 32'd1);
    repeat (3) tick();
    serial_in = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_bp = 10; m_ds = 8; m_ready = 0; m_ovr = 0; m_frm = 0;
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_enable", 32'(enable_timer), 32'd0);
    check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("midrst_bit_period", 32'(bit_period), 32'd10);
    check("midrst_data_size", 32'(data_size), 32'd8);
    check_flags("midrst");
    tick();

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: do_config(int'($urandom_range(2, 40)), int'($urandom_range(0, 9)));
        1: do_glitch();
        2: do_frame(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)));
        3: do_frame(1'b0, 1'b0, int'($urandom_range(0, 20)));
        default: do_read();
      endcase
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
